// File: rtl/fp_pkg.sv
// Shared FP-datapath definitions: shift-op encoding and helpers that split the
// shift amount into contiguous per-stage bit groups.
package fp_pkg;

  typedef enum logic [1:0] {
    SH_LSR = 2'b00,
    SH_ASR = 2'b01,
    SH_LSL = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  // Each stage resolves ceil(shamt_w/stages) amount bits, LSB group first.
  function automatic int unsigned group_lo(int unsigned stage, int unsigned shamt_w,
                                           int unsigned stages);
    return stage * ((shamt_w + stages - 1) / stages);
  endfunction

  function automatic int unsigned group_hi(int unsigned stage, int unsigned shamt_w,
                                           int unsigned stages);
    int unsigned hi;
    hi = group_lo(stage, shamt_w, stages) + (shamt_w + stages - 1) / stages;
    return (hi > shamt_w) ? shamt_w : hi;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter pipeline stage: shifts by the shamt bits in [LO, HI),
// updates guard/sticky for logical right shifts and registers the result.
module shift_stage
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned LO      = 0,
  parameter int unsigned HI      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  shift_op_e          in_op,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               in_guard,
  input  logic               in_sticky,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output shift_op_e          out_op,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_guard,
  output logic               out_sticky
);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    shift_op_e          op;
    logic [TAG_W-1:0]   tag;
    logic               guard;
    logic               sticky;
  } payload_t;

  payload_t           pay_d, pay_q;
  logic               valid_q;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   low_mask;
  logic               guard_bit;
  logic [2*WIDTH-1:0] rot;
  int unsigned        amt_u;

  always_comb begin
    pay_d = '{data: in_data, shamt: in_shamt, op: in_op, tag: in_tag,
              guard: 1'b0, sticky: 1'b0};
    amt   = '0;
    // Take this stage's amount group (already weighted) and clear it from the remainder.
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (i >= LO && i < HI) begin
        amt[i]         = in_shamt[i];
        pay_d.shamt[i] = 1'b0;
      end
    end
    amt_u     = 32'(amt);
    guard_bit = 1'b0;
    low_mask  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      low_mask[i] = (i + 2 <= amt_u);
      if (i + 1 == amt_u) guard_bit = in_data[i];
    end
    rot = {in_data, in_data} >> amt;

    unique case (in_op)
      SH_LSR: begin
        pay_d.data = in_data >> amt;
        if (amt_u == 0) begin
          pay_d.guard  = in_guard;
          pay_d.sticky = in_sticky;
        end else begin
          // The previous guard drops below the new guard and folds into sticky.
          pay_d.guard  = guard_bit;
          pay_d.sticky = in_sticky | in_guard | (|(in_data & low_mask));
        end
      end
      SH_ASR: pay_d.data = (amt_u >= WIDTH) ? {WIDTH{in_data[WIDTH-1]}}
                                            : $unsigned($signed(in_data) >>> amt);
      SH_LSL: pay_d.data = in_data << amt;
      SH_ROR: pay_d.data = rot[WIDTH-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else if (en) begin
      valid_q <= in_valid;
      pay_q   <= pay_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = pay_q.data;
  assign out_shamt  = pay_q.shamt;
  assign out_op     = pay_q.op;
  assign out_tag    = pay_q.tag;
  assign out_guard  = pay_q.guard;
  assign out_sticky = pay_q.sticky;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (LSR with guard/sticky, ASR, LSL, ROR) with a
// valid/ready handshake and a global stall on output backpressure.
module pipelined_barrel_shifter
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_guard,
  output logic               out_sticky,
  output logic [TAG_W-1:0]   out_tag
);

  logic                             adv;
  shift_op_e                        op0;
  logic [SHAMT_W-1:0]               shamt0;
  logic [STAGES-1:0]                vld, grd, stk;
  logic [STAGES-1:0][WIDTH-1:0]     dat;
  logic [STAGES-1:0][SHAMT_W-1:0]   sh;
  logic [STAGES-1:0][TAG_W-1:0]     tag;
  shift_op_e                        op [STAGES];
  logic                             unused_rem;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Rotation is reduced mod WIDTH up front so later stages never over-rotate.
  assign op0    = shift_op_e'(in_op);
  assign shamt0 = (op0 == SH_ROR) ? SHAMT_W'(32'(in_shamt) % WIDTH) : in_shamt;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic               v_in, g_in, s_in;
    logic [WIDTH-1:0]   d_in;
    logic [SHAMT_W-1:0] sh_in;
    shift_op_e          op_in;
    logic [TAG_W-1:0]   tag_in;

    if (s == 0) begin : g_first
      assign v_in   = in_valid;
      assign d_in   = in_data;
      assign sh_in  = shamt0;
      assign op_in  = op0;
      assign tag_in = in_tag;
      assign g_in   = 1'b0;
      assign s_in   = 1'b0;
    end else begin : g_next
      assign v_in   = vld[s-1];
      assign d_in   = dat[s-1];
      assign sh_in  = sh[s-1];
      assign op_in  = op[s-1];
      assign tag_in = tag[s-1];
      assign g_in   = grd[s-1];
      assign s_in   = stk[s-1];
    end

    shift_stage #(
      .WIDTH  (WIDTH),
      .SHAMT_W(SHAMT_W),
      .TAG_W  (TAG_W),
      .LO     (group_lo(s, SHAMT_W, STAGES)),
      .HI     (group_hi(s, SHAMT_W, STAGES))
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .in_valid  (v_in),
      .in_data   (d_in),
      .in_shamt  (sh_in),
      .in_op     (op_in),
      .in_tag    (tag_in),
      .in_guard  (g_in),
      .in_sticky (s_in),
      .out_valid (vld[s]),
      .out_data  (dat[s]),
      .out_shamt (sh[s]),
      .out_op    (op[s]),
      .out_tag   (tag[s]),
      .out_guard (grd[s]),
      .out_sticky(stk[s])
    );
  end

  assign out_valid  = vld[STAGES-1];
  assign out_data   = dat[STAGES-1];
  assign out_guard  = grd[STAGES-1];
  assign out_sticky = stk[STAGES-1];
  assign out_tag    = tag[STAGES-1];

  // Every amount bit is consumed by the last stage; its remainder and op are dead.
  assign unused_rem = (|sh[STAGES-1]) ^ (^op[STAGES-1]);

endmodule
